// File: rtl/pcie_pkg.sv
// Shared symbol format for the serial loopback link: 9-bit symbols, K flag in bit 0,
// payload byte in bits 8..1, shifted out LSB first.
package pcie_pkg;

  localparam int         SYM_W       = 9;
  localparam int         K_BIT       = 0;
  localparam logic [7:0] COM_DEFAULT = 8'hBC;

  typedef logic [SYM_W-1:0] sym_t;

  function automatic sym_t make_sym(input logic k, input logic [7:0] b);
    return {b, k};
  endfunction

endpackage

// File: rtl/pcie_byte_rx.sv
// Receiver: deserializes the loopback line, finds the COM phase and, once locked,
// emits one strobe per data (K=0) symbol at every symbol boundary.
module pcie_byte_rx
  import pcie_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_DEFAULT,
  parameter int         LOCK_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sync_ok
);

  sym_t       sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] phase_q, phase_d;
  logic [7:0] hits_q, hits_d;
  logic [7:0] hits_n;
  logic       sync_q, sync_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       com_hit;

  // First bit received lands in the LSB once the symbol is complete.
  assign com_hit = (sr_q == make_sym(1'b1, COM_SYMBOL));

  always_comb begin
    sr_d    = {ser_in, sr_q[SYM_W-1:1]};
    cnt_d   = (cnt_q == 4'(SYM_W - 1)) ? 4'd0 : cnt_q + 4'd1;
    phase_d = phase_q;
    hits_d  = hits_q;
    hits_n  = 8'd0;
    sync_d  = sync_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (!sync_q) begin
      if (com_hit) begin
        hits_n  = (hits_q != 8'd0 && phase_q == cnt_q) ? hits_q + 8'd1 : 8'd1;
        phase_d = cnt_q;
        hits_d  = hits_n;
        if (int'(hits_n) >= LOCK_COUNT) sync_d = 1'b1;
      end
    end else if (cnt_q == phase_q && !sr_q[K_BIT]) begin
      data_d  = sr_q[SYM_W-1:1];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= 4'd0;
      phase_q <= 4'd0;
      hits_q  <= 8'd0;
      sync_q  <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hits_q  <= hits_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sync_ok   = sync_q;

endmodule

// File: rtl/pcie.sv
// Byte link top: one-entry holding register and serializer feeding a registered
// serial loopback line into the byte receiver.
module pcie
  import pcie_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_DEFAULT,
  parameter int         INIT_IDLES = 4,
  parameter int         LOCK_COUNT = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA,
  input  logic       Valid,
  output logic       Ready,
  output logic [7:0] DATA_OUT,
  output logic       VALID_OUT,
  output logic       SYNC_OK
);

  logic [3:0]  sym_cnt_q, sym_cnt_d;
  sym_t        tx_sr_q, tx_sr_d;
  logic        ser_q, ser_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] init_cnt_q, init_cnt_d;
  logic        init_done_q, init_done_d;
  logic        load;

  assign load  = (sym_cnt_q == 4'd0);
  assign Ready = !hold_full_q && init_done_q;

  always_comb begin
    sym_cnt_d   = (sym_cnt_q == 4'(SYM_W - 1)) ? 4'd0 : sym_cnt_q + 4'd1;
    ser_d       = tx_sr_q[0];
    tx_sr_d     = tx_sr_q >> 1;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (load) begin
      if (hold_full_q) begin
        tx_sr_d     = make_sym(1'b0, hold_q);
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d = make_sym(1'b1, COM_SYMBOL);
      end
      // Reaching INIT_IDLES at a load edge means the last init idle has fully left.
      if (init_cnt_q == 16'(INIT_IDLES)) init_done_d = 1'b1;
      else                               init_cnt_d  = init_cnt_q + 16'd1;
    end
    if (Valid && Ready) begin
      hold_d      = DATA;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sym_cnt_q   <= 4'd0;
      tx_sr_q     <= '0;
      ser_q       <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      init_cnt_q  <= 16'd0;
      init_done_q <= 1'b0;
    end else begin
      sym_cnt_q   <= sym_cnt_d;
      tx_sr_q     <= tx_sr_d;
      ser_q       <= ser_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  pcie_byte_rx #(
    .COM_SYMBOL (COM_SYMBOL),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_rx (
    .clk       (CLK),
    .rst       (RESET),
    .ser_in    (ser_q),
    .data_out  (DATA_OUT),
    .valid_out (VALID_OUT),
    .sync_ok   (SYNC_OK)
  );

endmodule

// File: tb/tb_pcie.sv
// Scoreboard bench for the pcie loopback link: accepted bytes are queued with the
// edge index at which their strobe is due and matched against the receiver output.
`timescale 1ns/1ps
module tb_pcie;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] DATA;
  logic       Valid;
  logic       Ready;
  logic [7:0] DATA_OUT;
  logic       VALID_OUT;
  logic       SYNC_OK;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  int         next_idx = 0;
  logic [7:0] last_data = 8'h00;

  pcie dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DATA      (DATA),
    .Valid     (Valid),
    .Ready     (Ready),
    .DATA_OUT  (DATA_OUT),
    .VALID_OUT (VALID_OUT),
    .SYNC_OK   (SYNC_OK)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Monitor: edge E0 is the first rising edge after reset release.
  always begin
    int   cur;
    logic exp_strobe;
    exp_t e;
    @(posedge CLK);
    if (RESET) begin
      next_idx = 0;
      #1;
      last_data = 8'h00;
      check_eq("rst_ready", Ready, 0);
      check_eq("rst_valid", VALID_OUT, 0);
      check_eq("rst_sync", SYNC_OK, 0);
      check_eq("rst_data", DATA_OUT, 0);
    end else begin
      cur = next_idx;
      next_idx++;
      #1;
      exp_strobe = (sb.size() > 0) && (sb[0].at == cur);
      check_eq("strobe", VALID_OUT, exp_strobe);
      if (exp_strobe) begin
        e = sb.pop_front();
        if (VALID_OUT) begin
          check_eq("data", DATA_OUT, e.data);
          last_data = e.data;
        end
      end else if (!VALID_OUT) begin
        check_eq("hold", DATA_OUT, last_data);
      end
      check_eq("sync", SYNC_OK, (cur >= 20) ? 1 : 0);
      if (cur == 35) check_eq("rdy_init", Ready, 0);
      if (cur == 36) check_eq("rdy_up", Ready, 1);
    end
  end

  // Load happens at the first multiple of 9 strictly after the accept edge; strobe 11 later.
  task automatic send_byte(input logic [7:0] b, input bit keep_valid);
    bit done = 0;
    Valid = 1'b1;
    DATA  = b;
    for (int i = 0; i < 40 && !done; i++) begin
      if (Ready) begin
        sb.push_back('{data: b, at: ((next_idx / 9) + 1) * 9 + 11});
        $display("send 0x%02h accepted at edge %0d", b, next_idx);
        @(negedge CLK);
        check_eq("rdy_full", Ready, 0);
        done = 1;
      end else begin
        @(negedge CLK);
      end
    end
    if (!done) check_eq("send_timeout", 0, 1);
    if (!keep_valid) Valid = 1'b0;
  endtask

  task automatic init_phase();
    while (next_idx < 60) begin
      if (next_idx >= 5 && next_idx <= 30) begin
        Valid = 1'b1;
        DATA  = 8'h55;
        check_eq("init_ignored", Ready, 0);
      end else begin
        Valid = 1'b0;
      end
      @(negedge CLK);
    end
    Valid = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    sb.delete();
    last_data = 8'h00;
    check_eq("arst_ready", Ready, 0);
    check_eq("arst_valid", VALID_OUT, 0);
    check_eq("arst_sync", SYNC_OK, 0);
    check_eq("arst_data", DATA_OUT, 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    Valid = 1'b0;
    DATA  = 8'h00;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    init_phase();

    send_byte(8'hA5, 0);
    repeat (30) @(negedge CLK);

    for (int i = 0; i < 16; i++) send_byte(8'(i), 1);
    Valid = 1'b0;
    repeat (30) @(negedge CLK);

    send_byte(8'hBC, 0);
    repeat (30) @(negedge CLK);

    send_byte(8'h3C, 0);
    repeat (10) @(negedge CLK);
    $display("reset asserted with 0x3C in flight");
    do_reset();
    Valid = 1'b0;
    repeat (60) @(negedge CLK);

    send_byte(8'h7E, 0);
    repeat (30) @(negedge CLK);

    check_eq("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
